// File: rtl/regfile_bist_pkg.sv
// Shared definitions for the register-file built-in self-test.
// Holds the controller state encoding, the address/data widths, the
// register count and the default base test pattern.
package regfile_bist_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;

  localparam logic [DATA_W-1:0] PATTERN_DEFAULT = 32'hA5A5_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_bist_pattern.sv
// Test-word generator for the register-file self-test.
// Maps (address, pass index) to the word written during WRITE and to the
// word expected back during READ for both read ports.
//   wr_addr   : address currently being written
//   rd_addr_a : port A read address
//   rd_addr_b : port B read address
//   pass_idx  : 0 = true pattern, 1 = inverted pattern
//   wr_word   : data to write at wr_addr
//   exp_a     : expected read data at rd_addr_a
//   exp_b     : expected read data at rd_addr_b
module regfile_bist_pattern
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = PATTERN_DEFAULT,
  parameter bit                R0_ZERO = 1'b1
) (
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              pass_idx,
  output logic [DATA_W-1:0] wr_word,
  output logic [DATA_W-1:0] exp_a,
  output logic [DATA_W-1:0] exp_b
);

  function automatic logic [DATA_W-1:0] pass_word(input logic [ADDR_W-1:0] addr,
                                                  input logic              p);
    logic [DATA_W-1:0] base;
    base = PATTERN | {{(DATA_W-ADDR_W){1'b0}}, addr};
    return p ? ~base : base;
  endfunction

  // A hardwired-zero r0 never reflects what was written to it.
  function automatic logic [DATA_W-1:0] expect_word(input logic [ADDR_W-1:0] addr,
                                                    input logic              p);
    if (R0_ZERO && (addr == '0)) return '0;
    return pass_word(addr, p);
  endfunction

  assign wr_word = pass_word(wr_addr, pass_idx);
  assign exp_a   = expect_word(rd_addr_a, pass_idx);
  assign exp_b   = expect_word(rd_addr_b, pass_idx);

endmodule

// File: rtl/regfile_bist.sv
// Register-file self-test controller.
// Writes every register with a pattern, reads it back two registers per
// cycle, then repeats with the inverted pattern. Stops at the first
// mismatch and reports where it happened.
//   clk, Reset           : clock, synchronous active-high reset
//   start                : one-cycle run request (honoured only in IDLE)
//   busy, done, pass     : run in progress, end-of-run pulse, last result
//   fail_addr, fail_pass : register and pass index of the first mismatch
//   R_Addr_A/B, R_Data_A/B            : register-file read ports
//   W_Addr, W_Data, Write_Reg         : register-file write port
//
// state | meaning
// IDLE  | waiting for start, all bus outputs at 0
// WRITE | writing register cnt with the current pass word
// READ  | reading registers 2*cnt and 2*cnt+1 and comparing
// DONE  | one-cycle done pulse, result outputs valid
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = PATTERN_DEFAULT,
  parameter bit                R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_pass,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B
);

  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(REG_COUNT - 1);
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(REG_COUNT / 2 - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              pass_idx, pass_idx_nx;
  logic              pass_nx;
  logic [ADDR_W-1:0] fail_addr_nx;
  logic              fail_pass_nx;

  logic [ADDR_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] wr_word, exp_a, exp_b;
  logic              mism_a, mism_b;

  // In READ the counter indexes register pairs.
  assign rd_a = {cnt[ADDR_W-2:0], 1'b0};
  assign rd_b = {cnt[ADDR_W-2:0], 1'b1};

  regfile_bist_pattern #(
    .PATTERN (PATTERN),
    .R0_ZERO (R0_ZERO)
  ) u_pattern (
    .wr_addr   (cnt),
    .rd_addr_a (rd_a),
    .rd_addr_b (rd_b),
    .pass_idx  (pass_idx),
    .wr_word   (wr_word),
    .exp_a     (exp_a),
    .exp_b     (exp_b)
  );

  assign mism_a = (R_Data_A != exp_a);
  assign mism_b = (R_Data_B != exp_b);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pass_idx  <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_pass <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pass_idx  <= pass_idx_nx;
      pass      <= pass_nx;
      fail_addr <= fail_addr_nx;
      fail_pass <= fail_pass_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pass_idx_nx  = pass_idx;
    pass_nx      = pass;
    fail_addr_nx = fail_addr;
    fail_pass_nx = fail_pass;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx     = WRITE;
          cnt_nx       = '0;
          pass_idx_nx  = 1'b0;
          pass_nx      = 1'b0;
          fail_addr_nx = '0;
          fail_pass_nx = 1'b0;
        end
      end
      WRITE: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST_WR) begin
          state_nx = READ;
          cnt_nx   = '0;
        end
      end
      READ: begin
        cnt_nx = cnt + 1'b1;
        if (mism_a || mism_b) begin
          state_nx     = DONE;
          cnt_nx       = '0;
          pass_nx      = 1'b0;
          fail_addr_nx = mism_a ? rd_a : rd_b;
          fail_pass_nx = pass_idx;
        end else if (cnt == LAST_RD) begin
          cnt_nx = '0;
          if (!pass_idx) begin
            state_nx    = WRITE;
            pass_idx_nx = 1'b1;
          end else begin
            state_nx = DONE;
            pass_nx  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == WRITE) || (state == READ);
  assign done      = (state == DONE);
  assign Write_Reg = (state == WRITE);
  assign W_Addr    = (state == WRITE) ? cnt     : '0;
  assign W_Data    = (state == WRITE) ? wr_word : '0;
  assign R_Addr_A  = (state == READ)  ? rd_a    : '0;
  assign R_Addr_B  = (state == READ)  ? rd_b    : '0;

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist. dut0 (R0_ZERO=1) and dut1
// (R0_ZERO=0) each drive a behavioural register file with r0 hardwired
// to zero; dut0's register file can have one bit stuck.
module tb_regfile_bist;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut0 signals
  logic        rst0, start0, busy0, done0, pass0, fp0, we0;
  logic [4:0]  fa0, ra_a0, ra_b0, wa0;
  logic [31:0] wd0, rd_a0, rd_b0;
  // dut1 signals
  logic        rst1, start1, busy1, done1, pass1, fp1, we1;
  logic [4:0]  fa1, ra_a1, ra_b1, wa1;
  logic [31:0] wd1, rd_a1, rd_b1;

  // stuck-bit fault knobs for dut0's register file
  logic        st_en = 1'b0;
  logic [4:0]  st_reg = '0;
  logic [4:0]  st_bit = '0;
  logic        st_val = 1'b0;

  regfile_bist #(.PATTERN(PAT), .R0_ZERO(1'b1)) dut0 (
    .clk(clk), .Reset(rst0), .start(start0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_addr(fa0), .fail_pass(fp0),
    .R_Addr_A(ra_a0), .R_Addr_B(ra_b0), .W_Addr(wa0), .W_Data(wd0),
    .Write_Reg(we0), .R_Data_A(rd_a0), .R_Data_B(rd_b0)
  );

  regfile_bist #(.PATTERN(PAT), .R0_ZERO(1'b0)) dut1 (
    .clk(clk), .Reset(rst1), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_addr(fa1), .fail_pass(fp1),
    .R_Addr_A(ra_a1), .R_Addr_B(ra_b1), .W_Addr(wa1), .W_Data(wd1),
    .Write_Reg(we1), .R_Data_A(rd_a1), .R_Data_B(rd_b1)
  );

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  always @(posedge clk) if (we0) mem0[wa0] <= wd0;
  always @(posedge clk) if (we1) mem1[wa1] <= wd1;

  always_comb begin
    rd_a0 = (ra_a0 == 5'd0) ? 32'h0 : mem0[ra_a0];
    rd_b0 = (ra_b0 == 5'd0) ? 32'h0 : mem0[ra_b0];
    if (st_en && ra_a0 == st_reg) rd_a0[st_bit] = st_val;
    if (st_en && ra_b0 == st_reg) rd_b0[st_bit] = st_val;
  end

  always_comb begin
    rd_a1 = (ra_a1 == 5'd0) ? 32'h0 : mem1[ra_a1];
    rd_b1 = (ra_b1 == 5'd0) ? 32'h0 : mem1[ra_b1];
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] word(input int a, input int p);
    logic [31:0] w;
    w = PAT | 32'(a);
    return (p == 1) ? ~w : w;
  endfunction

  // Whole-run outcome: every register is written before it is read, so the
  // value read is the pass word (r0 hardwired, optional stuck bit applied).
  function automatic void model_run(input int sreg, input int sbit, input bit sval,
                                    input bit sen, input bit r0z,
                                    output bit ep, output int eaddr,
                                    output bit efp, output int ebusy);
    logic [31:0] rd, ex;
    ep = 1'b1; eaddr = 0; efp = 1'b0; ebusy = 96;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 16; k++)
        for (int port = 0; port < 2; port++) begin
          int a;
          a  = 2 * k + port;
          rd = (a == 0) ? 32'h0 : word(a, p);
          if (sen && a == sreg) rd[sbit] = sval;
          ex = (r0z && a == 0) ? 32'h0 : word(a, p);
          if (rd != ex) begin
            ep = 1'b0; eaddr = a; efp = p[0]; ebusy = p * 48 + 32 + k + 1;
            return;
          end
        end
  endfunction

  // Start dut0, optionally pulse start again at busy cycle restart_at,
  // count busy cycles and record the cycle at which done appears.
  task automatic run0(input int restart_at, output int bc, output int done_at);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    bc = 0; done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      if (busy0) bc++;
      start0 = (restart_at > 0 && busy0 && bc == restart_at);
      if (done0) begin done_at = i; break; end
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    checks++;
    if ({busy0, done0, pass0, fa0, fp0, we0, wa0, wd0, ra_a0, ra_b0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fa=%0d fp=%b we=%b wa=%0d wd=%h ra=%0d rb=%0d, want all 0",
               busy0, done0, pass0, fa0, fp0, we0, wa0, wd0, ra_a0, ra_b0);
    end
    // reset and start together: reset wins
    @(negedge clk) begin rst0 = 1'b1; start0 = 1'b1; end
    @(negedge clk) begin rst0 = 1'b0; start0 = 1'b0; end
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || we0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b we=%b, want 0 0", busy0, we0);
    end
  endtask

  task automatic test_clean_run;
    int bc, wcount, rcount, done_at;
    logic [31:0] w5 [2];
    w5[0] = 32'hA5A5_0005; w5[1] = 32'h5A5A_FFFA;
    st_en = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    bc = 0; wcount = 0; rcount = 0; done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      if (busy0) bc++;
      if (we0) begin
        wcount++;
        checks++;
        if (!busy0 || wa0 !== 5'((wcount - 1) % 32) || wd0 !== word((wcount - 1) % 32, (wcount - 1) / 32)) begin
          errors++;
          $display("FAIL write_beat%0d: busy=%b addr=%0d data=%h, want busy=1 addr=%0d data=%h",
                   wcount, busy0, wa0, wd0, (wcount - 1) % 32, word((wcount - 1) % 32, (wcount - 1) / 32));
        end
        if (wa0 == 5'd5 && wcount <= 64) begin
          checks++;
          if (wd0 !== w5[(wcount - 1) / 32]) begin
            errors++;
            $display("FAIL w_data_at_5_pass%0d: got %h want %h", (wcount - 1) / 32, wd0, w5[(wcount - 1) / 32]);
          end
        end
      end else if (busy0) begin
        rcount++;
        checks++;
        if (ra_a0 !== 5'(2 * ((rcount - 1) % 16)) || ra_b0 !== 5'(2 * ((rcount - 1) % 16) + 1)) begin
          errors++;
          $display("FAIL read_addr_beat%0d: got A=%0d B=%0d want A=%0d B=%0d",
                   rcount, ra_a0, ra_b0, 2 * ((rcount - 1) % 16), 2 * ((rcount - 1) % 16) + 1);
        end
      end
      if (done0) begin done_at = i; break; end
      @(negedge clk);
    end
    checks++;
    if (bc != 96 || done_at != 97) begin
      errors++;
      $display("FAIL clean_timing: busy=%0d done_at=%0d, want 96 97", bc, done_at);
    end
    checks++;
    if (wcount != 64 || rcount != 32) begin
      errors++;
      $display("FAIL clean_beats: writes=%0d reads=%0d, want 64 32", wcount, rcount);
    end
    checks++;
    if (pass0 !== 1'b1) begin
      errors++;
      $display("FAIL clean_pass: got %b want 1", pass0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b busy=%b pass=%b, want 0 0 1", done0, busy0, pass0);
    end
  endtask

  task automatic test_back_to_back;
    int bc, done_at;
    run0(0, bc, done_at);
    checks++;
    if (bc != 96 || done_at != 97 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: busy=%0d done_at=%0d pass=%b, want 96 97 1", bc, done_at, pass0);
    end
  endtask

  task automatic test_stuck_reg7;
    int bc, done_at;
    st_en = 1'b1; st_reg = 5'd7; st_bit = 5'd0; st_val = 1'b0;
    run0(0, bc, done_at);
    st_en = 1'b0;
    checks++;
    if (bc != 36 || done_at != 37) begin
      errors++;
      $display("FAIL stuck7_timing: busy=%0d done_at=%0d, want 36 37", bc, done_at);
    end
    checks++;
    if (pass0 !== 1'b0 || fa0 !== 5'd7 || fp0 !== 1'b0) begin
      errors++;
      $display("FAIL stuck7_result: pass=%b fa=%0d fp=%b, want 0 7 0", pass0, fa0, fp0);
    end
  endtask

  task automatic test_random_faults;
    int bc, done_at, eaddr, ebusy;
    bit ep, efp;
    for (int n = 0; n < 10; n++) begin
      st_reg = 5'($urandom_range(0, 31));
      st_bit = 5'($urandom_range(0, 31));
      st_val = 1'($urandom_range(0, 1));
      st_en  = 1'b1;
      model_run(int'(st_reg), int'(st_bit), st_val, 1'b1, 1'b1, ep, eaddr, efp, ebusy);
      run0(0, bc, done_at);
      checks++;
      if (bc != ebusy || done_at != ebusy + 1 || pass0 !== ep) begin
        errors++;
        $display("FAIL rand%0d_run (reg=%0d bit=%0d val=%b): busy=%0d done_at=%0d pass=%b, want %0d %0d %b",
                 n, st_reg, st_bit, st_val, bc, done_at, pass0, ebusy, ebusy + 1, ep);
      end
      if (!ep) begin
        checks++;
        if (fa0 !== 5'(eaddr) || fp0 !== efp) begin
          errors++;
          $display("FAIL rand%0d_fail_loc: fa=%0d fp=%b, want %0d %b", n, fa0, fp0, eaddr, efp);
        end
      end
    end
    st_en = 1'b0;
  endtask

  task automatic test_restart_ignored;
    int bc, done_at;
    run0(20, bc, done_at);
    checks++;
    if (bc != 96 || done_at != 97 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: busy=%0d done_at=%0d pass=%b, want 96 97 1", bc, done_at, pass0);
    end
  endtask

  task automatic test_reset_midwrite;
    bit hit, saw;
    hit = 1'b0; saw = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (we0 && wa0 == 5'd10) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midwrite_reach: write cycle 10 not seen, got we=%b wa=%0d", we0, wa0);
    end
    rst0 = 1'b1;
    @(negedge clk) rst0 = 1'b0;
    checks++;
    if ({busy0, done0, pass0, fa0, fp0, we0, wa0, wd0, ra_a0, ra_b0} !== '0) begin
      errors++;
      $display("FAIL midwrite_reset: busy=%b done=%b pass=%b fa=%0d fp=%b we=%b wa=%0d wd=%h, want all 0",
               busy0, done0, pass0, fa0, fp0, we0, wa0, wd0);
    end
    for (int i = 0; i < 110; i++) begin
      if (done0 || busy0) saw = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL midwrite_no_done: activity seen after reset=%b, want 0", saw);
    end
  endtask

  task automatic test_r0_zero_off;
    int bc, done_at, eaddr, ebusy;
    bit ep, efp;
    model_run(0, 0, 1'b0, 1'b0, 1'b0, ep, eaddr, efp, ebusy);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    bc = 0; done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      if (busy1) bc++;
      if (done1) begin done_at = i; break; end
      @(negedge clk);
    end
    checks++;
    if (bc != ebusy || done_at != ebusy + 1) begin
      errors++;
      $display("FAIL r0off_timing: busy=%0d done_at=%0d, want %0d %0d", bc, done_at, ebusy, ebusy + 1);
    end
    checks++;
    if (pass1 !== 1'b0 || fa1 !== 5'd0 || fp1 !== 1'b0) begin
      errors++;
      $display("FAIL r0off_result: pass=%b fa=%0d fp=%b, want 0 0 0", pass1, fa1, fp1);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_clean_run();
    test_back_to_back();
    test_stuck_reg7();
    test_random_faults();
    test_restart_ignored();
    test_reset_midwrite();
    test_r0_zero_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
